// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared state types for the debouncer and the colour-cycling button FSM
package button_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_WAIT,
    S_HELD,
    S_RELEASE_WAIT
  } debounce_state_t;

  typedef enum logic [1:0] {
    C_RED,
    C_GREEN,
    C_BLUE
  } state_t;

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - generic N-flop asynchronous-reset synchronizer
module sync_chain #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - push-button debouncer with level and press/release pulses
// Auto-repeat of button_out while held is built only when DEBOUNCE_REPEAT_EN is defined.
module button_debouncer
  import button_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int BOUNCE_TICKS  = 1000,
  parameter int INVERT        = 0,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic button_in,
  output logic button_level,
  output logic button_out,
  output logic button_released
);

  localparam int CNT_W = $clog2(BOUNCE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BOUNCE_TICKS - 1);

  if (SYNC_STAGES < 2 || BOUNCE_TICKS < 1 || REPEAT_PERIOD < 1 || REPEAT_DELAY < 1)
  begin : g_bad_param
    $error("button_debouncer: illegal parameter value");
  end

  logic sync_raw;
  logic sync;

  // Reset value matches the pin's idle level so the post-inversion value reads released.
  sync_chain #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'(INVERT))
  ) u_sync (
    .clk   (clk),
    .rst_n (rst),
    .d     (button_in),
    .q     (sync_raw)
  );

  assign sync = sync_raw ^ 1'(INVERT);

  debounce_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             out_q, out_d;
  logic             rel_q, rel_d;

`ifdef DEBOUNCE_REPEAT_EN
  localparam int RCNT_W = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
  localparam logic [RCNT_W-1:0] RCNT_FIRST = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] RCNT_WRAP  = RCNT_W'(REPEAT_DELAY + REPEAT_PERIOD - 1);
  localparam logic [RCNT_W-1:0] RCNT_BASE  = RCNT_W'(REPEAT_DELAY);

  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    out_d   = 1'b0;
    rel_d   = 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
    rcnt_d  = rcnt_q;
`endif
    // A change of the synchronized level always wins over a pending ena tick.
    case (state_q)
      S_IDLE: begin
        if (sync) begin
          state_d = S_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      S_PRESS_WAIT: begin
        if (!sync) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (ena) begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_HELD;
            out_d   = 1'b1;
            level_d = 1'b1;
`ifdef DEBOUNCE_REPEAT_EN
            rcnt_d  = '0;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_HELD: begin
        if (!sync) begin
          state_d = S_RELEASE_WAIT;
          cnt_d   = '0;
        end
`ifdef DEBOUNCE_REPEAT_EN
        else if (ena) begin
          // After the first repeat the counter folds back so later repeats recur every REPEAT_PERIOD.
          if (rcnt_q == RCNT_WRAP) begin
            rcnt_d = RCNT_BASE;
            out_d  = 1'b1;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
            out_d  = (rcnt_q == RCNT_FIRST);
          end
        end
`endif
      end
      S_RELEASE_WAIT: begin
        if (sync) begin
          state_d = S_HELD;
        end else if (ena) begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_IDLE;
            rel_d   = 1'b1;
            level_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      out_q   <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      out_q   <= out_d;
      rel_q   <= rel_d;
    end
  end

`ifdef DEBOUNCE_REPEAT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rcnt_q <= '0;
    end else begin
      rcnt_q <= rcnt_d;
    end
  end
`endif

  assign button_level    = level_q;
  assign button_out      = out_q;
  assign button_released = rel_q;

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - scoreboard bench for button_debouncer (pulse kind and cycle checked)
module tb_button_debouncer;

  logic clk = 1'b0;
  logic rst;
  logic ena;
  logic button_in;
  logic button_level;
  logic button_out;
  logic button_released;

  button_debouncer #(
    .SYNC_STAGES   (2),
    .BOUNCE_TICKS  (4),
    .INVERT        (0),
    .REPEAT_DELAY  (8),
    .REPEAT_PERIOD (3)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ena             (ena),
    .button_in       (button_in),
    .button_level    (button_level),
    .button_out      (button_out),
    .button_released (button_released)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_rel;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic push(input bit is_rel, input int at);
    ev_t e;
    e.is_rel = is_rel;
    e.cyc    = at;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic act, input logic expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && (button_out === 1'b1 || button_released === 1'b1)) begin
      ev_t e;
      n_checks++;
      if (button_out && button_released) begin
        n_fail++;
        $display("FAIL pulse_overlap: out=%b released=%b at cycle %0d, required exclusive",
                 button_out, button_released, cyc);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end else if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: released=%b at cycle %0d, required no pulse",
                 button_released, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.is_rel != button_released || e.cyc != cyc) begin
          n_fail++;
          $display("FAIL pulse: got released=%b at cycle %0d, required released=%b at cycle %0d",
                   button_released, cyc, e.is_rel, e.cyc);
        end
      end
    end
  end

  initial begin
    int c;
    rst       = 1'b0;
    ena       = 1'b1;
    button_in = 1'b0;
    wait_cyc(3);
    chk("reset_level", button_level, 1'b0);
    chk("reset_out", button_out, 1'b0);
    chk("reset_released", button_released, 1'b0);
    rst = 1'b1;
    wait_cyc(5);

    // clean press
    c = cyc; button_in = 1'b1; push(1'b0, c + 7);
    wait_cyc(20);
    chk("press_level", button_level, 1'b1);

    // clean release
    c = cyc; button_in = 1'b0; push(1'b1, c + 7);
    wait_cyc(12);
    chk("release_level", button_level, 1'b0);

    // short high rejected
    button_in = 1'b1; wait_cyc(3);
    button_in = 1'b0; wait_cyc(12);
    chk("glitch_level", button_level, 1'b0);

    // bouncing press then stable
    for (int k = 0; k < 4; k++) begin
      button_in = (k % 2 == 0);
      wait_cyc(2);
    end
    c = cyc; button_in = 1'b1; push(1'b0, c + 7);
    wait_cyc(15);
    chk("bounce_press_level", button_level, 1'b1);

    // short low while held rejected
    button_in = 1'b0; wait_cyc(2);
    button_in = 1'b1; wait_cyc(15);
    chk("held_glitch_level", button_level, 1'b1);

    c = cyc; button_in = 1'b0; push(1'b1, c + 7);
    wait_cyc(12);

    // ena one cycle in four
    c = cyc; button_in = 1'b1; push(1'b0, c + 16);
    for (int i = 0; i < 24; i++) begin
      ena = (i % 4 == 3);
      @(negedge clk);
    end
    ena = 1'b1;
    chk("ena_gated_level", button_level, 1'b1);
    c = cyc; button_in = 1'b0; push(1'b1, c + 7);
    wait_cyc(12);

    // ena never high
    ena = 1'b0; button_in = 1'b1; wait_cyc(30);
    chk("ena_off_level", button_level, 1'b0);
    button_in = 1'b0; wait_cyc(5);
    ena = 1'b1; wait_cyc(5);

    // reset mid press-wait, pin held through reset
    button_in = 1'b1; wait_cyc(4);
    #2 rst = 1'b0;
    #1;
    chk("rst_pw_level", button_level, 1'b0);
    chk("rst_pw_out", button_out, 1'b0);
    wait_cyc(3);
    c = cyc; rst = 1'b1; push(1'b0, c + 7);
    wait_cyc(15);
    chk("rst_pw_after_level", button_level, 1'b1);

    // reset while held: level drops without a clock edge
    #2 rst = 1'b0;
    #1;
    chk("rst_held_level", button_level, 1'b0);
    wait_cyc(2);
    c = cyc; rst = 1'b1; push(1'b0, c + 7);
    wait_cyc(15);
    chk("rst_held_after_level", button_level, 1'b1);

    c = cyc; button_in = 1'b0; push(1'b1, c + 7);
    wait_cyc(12);

    // long hold: auto-repeat when built in, single pulse otherwise
    c = cyc; button_in = 1'b1; push(1'b0, c + 7);
`ifdef DEBOUNCE_REPEAT_EN
    for (int t = c + 15; t <= c + 32; t += 3) push(1'b0, t);
`endif
    wait_cyc(30);
    chk("long_hold_level", button_level, 1'b1);
    button_in = 1'b0; push(1'b1, c + 37);
    wait_cyc(15);
    chk("final_level", button_level, 1'b0);

    wait_cyc(10);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_pulses: %0d still pending, required 0 (next due cycle %0d)",
               exp_q.size(), exp_q[0].cyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
